// File: rtl/irq_encoder32_5.sv
// Edge-capturing 32-to-5 interrupt priority encoder with valid/ack grant handshake.
// Define IRQ_ENCODER_ROUND_ROBIN_EN for rotating priority instead of lowest-index-wins.
module irq_encoder32_5 #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] notReq,
  input  logic [31:0] mask,
  input  logic        irqAck,
  output logic        irqValid,
  output logic [4:0]  irqId,
  output logic [31:0] pending,
  output logic        overrun
);

  typedef enum logic [0:0] {StIdle, StPresent} state_e;

  state_e      r_state, w_state_d;
  logic [31:0] r_sync [SYNC_STAGES];
  logic [31:0] r_prev;
  logic [31:0] r_pending, w_pending_d;
  logic [4:0]  r_id, w_id_d;
  logic        r_overrun, w_overrun_d;
  logic [31:0] w_sync, w_edge, w_clr, w_elig;
  logic [4:0]  w_win;
  logic        w_any;

  // Flops reset to 1 so a line held low through reset still yields one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '1;
      r_prev <= '1;
    end else begin
      r_sync[0] <= notReq;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_edge = ~w_sync & r_prev;
  assign w_elig = r_pending & mask;
  assign w_any  = |w_elig;

`ifdef IRQ_ENCODER_ROUND_ROBIN_EN
  logic [4:0] r_rr_last;
  logic [4:0] w_start, w_idx;

  assign w_start = r_rr_last + 5'd1;

  // Scan offsets high to low so the smallest offset from the start wins.
  always_comb begin
    w_win = '0;
    w_idx = '0;
    for (int k = 31; k >= 0; k--) begin
      w_idx = w_start + k[4:0];
      if (w_elig[w_idx]) w_win = w_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_last <= '0;
    end else if (r_state == StPresent && irqAck) begin
      r_rr_last <= r_id;
    end
  end
`else
  always_comb begin
    w_win = '0;
    for (int k = 31; k >= 0; k--) begin
      if (w_elig[k[4:0]]) w_win = k[4:0];
    end
  end
`endif

  always_comb begin
    w_state_d = r_state;
    w_id_d    = r_id;
    w_clr     = '0;
    unique case (r_state)
      StIdle: begin
        if (w_any) begin
          w_id_d    = w_win;
          w_state_d = StPresent;
        end
      end
      StPresent: begin
        if (irqAck) begin
          w_clr[r_id] = 1'b1;
          w_state_d   = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
    // A new edge on the bit being retired re-arms it without counting as overrun.
    w_pending_d = (r_pending & ~w_clr) | w_edge;
    w_overrun_d = |(w_edge & r_pending & ~w_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_id      <= '0;
      r_pending <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_id      <= w_id_d;
      r_pending <= w_pending_d;
      r_overrun <= w_overrun_d;
    end
  end

  assign irqValid = (r_state == StPresent);
  assign irqId    = r_id;
  assign pending  = r_pending;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_irq_encoder32_5.sv
// Self-checking bench for irq_encoder32_5: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the edge/pending/grant rules.
module tb_irq_encoder32_5;
  localparam int unsigned S = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] notReq;
  logic [31:0] mask;
  logic        irqAck;
  logic        irqValid;
  logic [4:0]  irqId;
  logic [31:0] pending;
  logic        overrun;

  irq_encoder32_5 #(.SYNC_STAGES(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .notReq   (notReq),
    .mask     (mask),
    .irqAck   (irqAck),
    .irqValid (irqValid),
    .irqId    (irqId),
    .pending  (pending),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_ovr = 0;
  int dut_grants[$];
  logic prev_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: samples of each line, delayed S cycles, define edges.
  logic [31:0] m_hist [S+1];
  logic [31:0] m_pend;
  logic        m_valid;
  logic [4:0]  m_id;
  logic        m_ovr;

  function automatic int lowest(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int j = 0; j <= S; j++) m_hist[j] = '1;
    m_pend  = '0;
    m_valid = 1'b0;
    m_id    = '0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] edg, clr;
    int w;
    if (rst) begin
      model_reset();
      return;
    end
    edg = ~m_hist[S-1] & m_hist[S];
    for (int j = S; j >= 1; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = notReq;
    clr = '0;
    if (m_valid && irqAck) clr[m_id] = 1'b1;
    m_ovr = |(edg & m_pend & ~clr);
    if (!m_valid) begin
      w = lowest(m_pend & mask);
      if (w >= 0) begin
        m_valid = 1'b1;
        m_id    = w[4:0];
      end
    end else if (irqAck) begin
      m_valid = 1'b0;
    end
    m_pend = (m_pend & ~clr) | edg;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("valid", irqValid, m_valid);
    if (m_valid) check("id", irqId, m_id);
    check("pending", pending, m_pend);
    check("overrun", overrun, m_ovr);
    if (irqValid && !prev_valid) dut_grants.push_back(int'(irqId));
    if (overrun) n_ovr++;
    prev_valid = irqValid;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_valid", irqValid, 0);
    check("rst_pending", pending, 0);
    check("rst_overrun", overrun, 0);
    check("rst_id", irqId, 0);
    repeat (n) cycle();
    rst = 1'b0;
    prev_valid = 1'b0;
  endtask

  task automatic ack_loop(input int n);
    repeat (n) begin
      irqAck = irqValid;
      cycle();
    end
    irqAck = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int c = 0;
    while (!irqValid && c < budget) begin
      cycle();
      c++;
    end
    check("wait_valid", irqValid, 1);
  endtask

  initial begin
    notReq = '1;
    mask   = '1;
    irqAck = 1'b0;
    @(negedge clk);
    do_reset(2);

    // Quiet after reset
    repeat (10) cycle();
    check("quiet_pending", pending, 0);
    check("quiet_valid", irqValid, 0);

    // Single-source latency
    notReq[5] = 1'b0;
    cycle();
    cycle();
    check("lat_pend_k1", pending, 0);
    cycle();
    check("lat_pend_k2", pending, 32'h20);
    check("lat_valid_k2", irqValid, 0);
    cycle();
    check("lat_valid_k3", irqValid, 1);
    check("lat_id_k3", irqId, 5);
    cycle();
    irqAck = 1'b1;
    cycle();
    irqAck = 1'b0;
    check("lat_ack_pend", pending, 0);
    check("lat_ack_valid", irqValid, 0);
    notReq[5] = 1'b1;
    repeat (3) cycle();

    // Priority and masking
    mask = 32'hFFFF_FFF7;
    dut_grants.delete();
    notReq[3] = 1'b0; notReq[7] = 1'b0; notReq[30] = 1'b0;
    ack_loop(14);
    check("prio_count", dut_grants.size(), 2);
    if (dut_grants.size() >= 2) begin
      check("prio_first", dut_grants[0], 7);
      check("prio_second", dut_grants[1], 30);
    end
    check("prio_held", pending, 32'h8);
    mask = '1;
    dut_grants.delete();
    ack_loop(6);
    check("unmask_count", dut_grants.size(), 1);
    if (dut_grants.size() >= 1) check("unmask_grant", dut_grants[0], 3);
    notReq = '1;
    repeat (4) cycle();

    // Overrun and merge
    n_ovr = 0;
    dut_grants.delete();
    notReq[12] = 1'b0;
    repeat (2) cycle();
    notReq[12] = 1'b1;
    repeat (2) cycle();
    notReq[12] = 1'b0;
    repeat (6) cycle();
    check("ovr_pulses", n_ovr, 1);
    ack_loop(8);
    check("ovr_grants", dut_grants.size(), 1);
    if (dut_grants.size() >= 1) check("ovr_grant_id", dut_grants[0], 12);
    notReq[12] = 1'b1;
    repeat (3) cycle();

    // Edge landing on the ack edge of the same bit
    notReq[12] = 1'b0;
    cycle();
    cycle();
    notReq[12] = 1'b1;
    cycle();
    notReq[12] = 1'b0;
    cycle();
    check("ea_valid", irqValid, 1);
    cycle();
    irqAck = 1'b1;
    cycle();
    irqAck = 1'b0;
    check("ea_pend12", 32'(pending[12]), 1);
    check("ea_overrun", overrun, 0);
    check("ea_valid_gap", irqValid, 0);
    cycle();
    check("ea_regrant_v", irqValid, 1);
    check("ea_regrant_id", irqId, 12);
    notReq[12] = 1'b1;
    irqAck = 1'b1;
    cycle();
    irqAck = 1'b0;
    repeat (4) cycle();
    check("ea_clean", pending, 0);

    // Grant stability
    notReq[9] = 1'b0;
    wait_valid(8);
    check("stab_start", irqId, 9);
    mask[9] = 1'b0;
    notReq[1] = 1'b0;
    repeat (20) begin
      cycle();
      check("stab_valid", irqValid, 1);
      check("stab_id", irqId, 9);
    end
    dut_grants.delete();
    irqAck = 1'b1;
    cycle();
    irqAck = 1'b0;
    repeat (3) cycle();
    check("stab_next_n", dut_grants.size(), 1);
    if (dut_grants.size() >= 1) check("stab_next", dut_grants[0], 1);
    ack_loop(4);
    notReq = '1;
    mask = '1;
    repeat (4) cycle();

    // Reset mid-handshake with a line held low
    notReq[0] = 1'b0; notReq[2] = 1'b0; notReq[8] = 1'b0;
    wait_valid(8);
    check("mid_pend", pending, 32'h105);
    check("mid_id", irqId, 0);
    notReq[0] = 1'b1; notReq[2] = 1'b1;
    do_reset(2);
    dut_grants.delete();
    ack_loop(10);
    check("mid_grants", dut_grants.size(), 1);
    if (dut_grants.size() >= 1) check("mid_grant8", dut_grants[0], 8);
    notReq = '1;
    repeat (4) cycle();

    // Random traffic
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 99) < 10) notReq[$urandom_range(0, 31)] ^= 1'b1;
      if ($urandom_range(0, 99) < 2) notReq = notReq ^ ($urandom & $urandom & $urandom);
      if ($urandom_range(0, 99) < 4) mask = $urandom | $urandom;
      irqAck = (irqValid && $urandom_range(0, 3) != 0) || ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 999) == 0) do_reset(1);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
